conv_stream_engine: RTL
=======================

Name: conv_stream_engine

Overview:
- Parametrised successor to the fixed 3x3 line-buffer/convolve pair.
- Accepts a raster-order pixel stream over valid/ready and buffers K-1 rows internally.
- Forms a KxK window and emits one signed multiply-accumulate result per strided window position over valid/ready.
- Sits between the image feature source and the activation/pooling stages of the NPU datapath.

Parameters:
BIT_DEPTH, 8, unsigned pixel width
WT_WIDTH, 8, signed weight width
COLS, 28, image width in pixels
ROWS, 28, image height in pixels
K, 3, kernel size (KxK), legal 2..5
ACC_WIDTH, 24, signed result width; must be >= BIT_DEPTH+WT_WIDTH+clog2(K*K)+1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
start  in  1  begin a frame; sampled only in IDLE
stride  in  2  window step 1..3; 0 treated as 1; latched on start
w_wr_en  in  1  weight write strobe; honoured only in IDLE
w_addr  in  clog2(K*K)  weight index, row-major (0 = top-left)
w_data  in  WT_WIDTH  signed weight
pix_valid  in  1  input pixel valid
pix_data  in  BIT_DEPTH  input pixel
pix_ready  out  1  engine accepts pixel
out_valid  out  1  result valid
out_data  out  ACC_WIDTH  signed window sum
out_ready  in  1  downstream accepts result
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (rst=0 at clk edge):
  - State goes to IDLE.
  - pix_ready=0, out_valid=0, out_data=0, busy=0, done=0.
  - Row/col counters = 0; all weights = 0.
  - Line-buffer contents are don't-care.
  - Reset mid-frame abandons the frame; no done pulse.
- FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE: start=1 latches the stride, clears the counters and goes to RUN. w_wr_en=1 writes w_data to weight[w_addr]. If both are asserted in the same cycle, the write completes and the frame starts.
  - RUN: pix_ready = !out_valid || out_ready (whole-pipeline stall). A handshake is pix_valid && pix_ready.
  - After the handshake on pixel ROWS*COLS-1, go to DRAIN.
  - DRAIN: wait until out_valid=0 or out_valid&&out_ready, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Start while busy is ignored. w_wr_en outside IDLE is ignored.
- Datapath on each input handshake:
  - Pixel at (r,c) is written to the row buffer.
  - The KxK window shifts one column left.
  - The new right column is {K-1 buffered pixels of column c from rows r-K+1..r-1, pix_data}.
  - c wraps COLS-1 -> 0 with r+1.
- Window emission: when r>=K-1, c>=K-1, (r-K+1)%stride==0 and (c-K+1)%stride==0, out_data <= sum over i of zero-extended pixel[i] times sign-extended weight[i]. The sum is computed in ACC_WIDTH, with no saturation or truncation when the parameter rule holds.
- Latency: out_valid rises on the clock edge after the handshake of the window's bottom-right pixel.
- out_valid/out_data hold stable until out_valid && out_ready.
- A new result and the acceptance of the old one in the same cycle is legal: the register reloads, out_valid stays 1.
- Output count per frame: ((ROWS-K)/stride+1)*((COLS-K)/stride+1), floor division.
- No windows span a row wrap; columns c<K-1 never emit.
- pix_ready is 0 in IDLE, DRAIN and DONE.

Optional Feature:
- Macro CONV_STREAM_RELU_EN.
  - Defined: out_data is clamped to 0 when the signed sum is negative, applied before the output register. Latency is unchanged.
  - Undefined: the raw signed sum is output.

Test Plan:
1. COLS=ROWS=6, K=3, stride=1, all weights 1, all pixels 2 -> 16 outputs, each 18; done pulses once, one cycle after the last output handshake; busy then 0.
2. Same size, stride=2, weight[4]=1 and others 0, pixel=r*6+c -> exactly 4 outputs: 7, 9, 19, 21 in order.
3. Case 1 with out_ready held 0 for 5 cycles mid-frame -> pix_ready=0 during the stall, out_data stable, still 16 outputs of 18, no loss or duplicate.
4. All weights -1 (0xFF), all pixels 255 -> every output -2295. With CONV_STREAM_RELU_EN defined, every output 0.
5. Reset (rst=0) after 10 pixels, then reload weights and rerun case 1 -> out_valid/busy 0 during reset, no done pulse, second frame gives 16x18.
6. stride=0 behaves as case 1. start and w_wr_en pulses during RUN are ignored: output values and count are unchanged.

Source files
------------

// File: rtl/conv_stream_engine.sv
// conv_stream_engine: streaming KxK signed MAC over a raster pixel stream.
// Ports: i_clk, i_rst (sync, active-low), i_start/i_stride frame control,
//   i_w_wr_en/i_w_addr/i_w_data weight load, i_pix_valid/i_pix_data/o_pix_ready
//   pixel input, o_out_valid/o_out_data/i_out_ready result output, o_busy, o_done.
// Optional macro CONV_STREAM_RELU_EN clamps negative sums to zero.
module conv_stream_engine #(
   parameter int BIT_DEPTH = 8,
   parameter int WT_WIDTH  = 8,
   parameter int COLS      = 28,
   parameter int ROWS      = 28,
   parameter int K         = 3,
   parameter int ACC_WIDTH = 24
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_start,
   input  logic [1:0]                   i_stride,
   input  logic                         i_w_wr_en,
   input  logic [$clog2(K*K)-1:0]       i_w_addr,
   input  logic [WT_WIDTH-1:0]          i_w_data,
   input  logic                         i_pix_valid,
   input  logic [BIT_DEPTH-1:0]         i_pix_data,
   output logic                         o_pix_ready,
   output logic                         o_out_valid,
   output logic [ACC_WIDTH-1:0]         o_out_data,
   input  logic                         i_out_ready,
   output logic                         o_busy,
   output logic                         o_done
);

   localparam int NW = K * K;
   localparam int AW = $clog2(NW);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]                  r_state;
   logic [1:0]                  r_stride;
   logic [RW-1:0]               r_row;
   logic [CW-1:0]               r_col;
   logic [1:0]                  r_rph;
   logic [1:0]                  r_cph;
   logic signed [WT_WIDTH-1:0]  r_wt [NW];
   logic [BIT_DEPTH-1:0]        r_lb [K-1][COLS];
   logic [BIT_DEPTH-1:0]        r_win [K][K];
   logic                        r_out_valid;
   logic [ACC_WIDTH-1:0]        r_out_data;

   logic                        w_hs;
   logic                        w_col_end;
   logic                        w_last;
   logic                        w_emit;
   logic [1:0]                  w_step_max;
   logic [BIT_DEPTH-1:0]        w_nwin [K][K];
   logic signed [ACC_WIDTH-1:0] w_sum;
   logic signed [ACC_WIDTH-1:0] w_res;

   assign o_pix_ready = (r_state == S_RUN) && (!r_out_valid || i_out_ready);
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = (r_state == S_DONE);

   assign w_hs       = i_pix_valid && o_pix_ready;
   assign w_col_end  = (r_col == CW'(COLS - 1));
   assign w_last     = w_col_end && (r_row == RW'(ROWS - 1));
   assign w_step_max = r_stride - 2'd1;
   // Phase counters are zero exactly on rows/cols that land on the stride grid.
   assign w_emit     = (r_row >= RW'(K - 1)) && (r_col >= CW'(K - 1))
                       && (r_rph == 2'd0) && (r_cph == 2'd0);

   // Window as it will look after this pixel: shift left, new right column.
   always_comb begin
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K - 1; j++)
            w_nwin[i][j] = r_win[i][j+1];
      for (int i = 0; i < K - 1; i++)
         w_nwin[i][K-1] = r_lb[i][r_col];
      w_nwin[K-1][K-1] = i_pix_data;
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            w_sum = w_sum
                  + $signed(ACC_WIDTH'({1'b0, w_nwin[i][j]}))
                  * ACC_WIDTH'(r_wt[i*K+j]);
`ifdef CONV_STREAM_RELU_EN
      w_res = w_sum[ACC_WIDTH-1] ? '0 : w_sum;
`else
      w_res = w_sum;
`endif
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= S_IDLE;
         r_stride    <= 2'd1;
         r_row       <= '0;
         r_col       <= '0;
         r_rph       <= '0;
         r_cph       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         for (int n = 0; n < NW; n++)
            r_wt[n] <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (i_w_wr_en && ({1'b0, i_w_addr} < (AW+1)'(NW)))
                  r_wt[i_w_addr] <= i_w_data;
               if (i_start) begin
                  r_stride <= (i_stride == 2'd0) ? 2'd1 : i_stride;
                  r_row    <= '0;
                  r_col    <= '0;
                  r_rph    <= '0;
                  r_cph    <= '0;
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_hs) begin
                  if (w_col_end) begin
                     r_col <= '0;
                     r_cph <= '0;
                     r_row <= r_row + 1'b1;
                     if (r_row >= RW'(K - 1))
                        r_rph <= (r_rph == w_step_max) ? 2'd0 : r_rph + 2'd1;
                  end else begin
                     r_col <= r_col + 1'b1;
                     if (r_col >= CW'(K - 1))
                        r_cph <= (r_cph == w_step_max) ? 2'd0 : r_cph + 2'd1;
                  end
                  if (w_last)
                     r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!r_out_valid || i_out_ready)
                  r_state <= S_DONE;
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase

         // A new result may replace one being accepted in the same cycle.
         if (w_hs && w_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
         end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   // Row buffer keeps the K-1 previous rows per column, oldest at index 0.
   always_ff @(posedge i_clk) begin
      if (w_hs) begin
         for (int j = 0; j < K - 2; j++)
            r_lb[j][r_col] <= r_lb[j+1][r_col];
         r_lb[K-2][r_col] <= i_pix_data;
         r_win <= w_nwin;
      end
   end

endmodule
